// File: rtl/uart_rx_buffer_pkg.sv
// uart_rx_buffer_pkg: shared UART receive widths, error codes and FIFO entry layout
package uart_rx_buffer_pkg;
    localparam int WIDTH_DATABITS = 8;
    localparam int WIDTH_ERROR = 2;
    localparam int DEPTH_DEFAULT = 16;
    typedef enum logic [WIDTH_ERROR-1:0] {
        ERR_NONE   = 2'd0,
        ERR_PARITY = 2'd1,
        ERR_STOP   = 2'd2,
        ERR_FRAME  = 2'd3
    } err_e;
    typedef struct packed {
        logic [WIDTH_ERROR-1:0] err;
        logic [WIDTH_DATABITS-1:0] data;
    } entry_t;
    localparam int ENTRY_W = $bits(entry_t);
    // an error strobe always wins and carries no data, so the byte is discarded
    function automatic entry_t make_entry(
        input logic [WIDTH_DATABITS-1:0] data,
        input logic [WIDTH_ERROR-1:0] err,
        input logic is_err
    );
        entry_t e;
        e.err = is_err ? err : '0;
        e.data = is_err ? '0 : data;
        return e;
    endfunction
endpackage

// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer_if: receiver-to-buffer strobes and buffer-to-consumer valid/ready head
interface uart_rx_buffer_if;
    import uart_rx_buffer_pkg::*;
    logic [WIDTH_DATABITS-1:0] in_data;
    logic in_valid;
    logic [WIDTH_ERROR-1:0] in_error;
    logic in_error_valid;
    logic [WIDTH_DATABITS-1:0] out_data;
    logic [WIDTH_ERROR-1:0] out_err;
    logic out_valid;
    logic out_ready;
    modport master (
        output in_data, in_valid, in_error, in_error_valid, out_ready,
        input out_data, out_err, out_valid
    );
    modport slave (
        input in_data, in_valid, in_error, in_error_valid, out_ready,
        output out_data, out_err, out_valid
    );
endinterface

// File: rtl/uart_rx_buffer_ram.sv
// uart_rx_buffer_ram: unreset register array, sync write port and async read port
module uart_rx_buffer_ram #(
    parameter int DW = 10,
    parameter int AW = 4
) (
    input logic clk,
    input logic we,
    input logic [AW-1:0] wa,
    input logic [DW-1:0] wd,
    input logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    assign rd = mem[ra];
endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: FWFT FIFO of tagged UART bytes/errors with sticky overflow and error count
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input logic clk,
    input logic rst_n,
    uart_rx_buffer_if.slave bus,
    output logic [ADDR_W:0] level,
    output logic full,
    output logic empty,
    output logic overflow,
    output logic [7:0] err_count,
    input logic clear_status
);
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    entry_t wr_entry, rd_entry;
    logic push, pop, accept, drop, err_push;
    assign push = bus.in_valid | bus.in_error_valid;
    assign wr_entry = make_entry(bus.in_data, bus.in_error, bus.in_error_valid);
    assign empty = level == '0;
    assign full = level == (ADDR_W+1)'(DEPTH);
    assign bus.out_valid = !empty;
    assign pop = bus.out_valid & bus.out_ready;
    // a simultaneous pop frees the slot, so a full FIFO still takes the push
    assign accept = push & (!full | pop);
    assign drop = push & full & !pop;
    assign err_push = accept & (wr_entry.err != '0);
    assign bus.out_data = empty ? '0 : rd_entry.data;
    assign bus.out_err = empty ? '0 : rd_entry.err;
    uart_rx_buffer_ram #(.DW(ENTRY_W), .AW(ADDR_W)) u_ram (
        .clk(clk),
        .we(accept),
        .wa(wr_ptr),
        .wd(wr_entry),
        .ra(rd_ptr),
        .rd(rd_entry)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level <= '0;
            overflow <= 1'b0;
            err_count <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
            if (accept != pop) level <= accept ? level + (ADDR_W+1)'(1) : level - (ADDR_W+1)'(1);
            overflow <= drop | (overflow & !clear_status);
            if (err_push) err_count <= clear_status ? 8'd1 : err_count + 8'(err_count != 8'hFF);
            else if (clear_status) err_count <= '0;
        end
    end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed checks of ordering, full/overflow, error tagging, saturation and reset
module tb_uart_rx_buffer;
    import uart_rx_buffer_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_status = 1'b0;
    logic [4:0] level;
    logic full, empty, overflow;
    logic [7:0] err_count;
    int n_cmp = 0;
    int n_bad = 0;
    uart_rx_buffer_if bus ();
    uart_rx_buffer dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .level(level),
        .full(full),
        .empty(empty),
        .overflow(overflow),
        .err_count(err_count),
        .clear_status(clear_status)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic push_byte(input logic [7:0] d);
        bus.in_data = d;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
    endtask
    task automatic pop_one();
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
    endtask
    task automatic clear();
        clear_status = 1'b1;
        cyc();
        clear_status = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.in_error = '0;
        bus.in_error_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) cyc();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_data", bus.out_data, 0);
        rst_n = 1'b1;
        cyc();
        // two bytes, then drain
        push_byte(8'hA5);
        check("t1_valid", bus.out_valid, 1);
        check("t1_data0", bus.out_data, 8'hA5);
        check("t1_err0", bus.out_err, 0);
        push_byte(8'h3C);
        check("t1_level", level, 2);
        bus.out_ready = 1'b1;
        check("t1_pop_a5", bus.out_data, 8'hA5);
        cyc();
        check("t1_pop_3c", bus.out_data, 8'h3C);
        cyc();
        bus.out_ready = 1'b0;
        check("t1_empty", empty, 1);
        check("t1_valid_off", bus.out_valid, 0);
        // fill then overflow
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check("t2_full", full, 1);
        check("t2_ovf_pre", overflow, 0);
        push_byte(8'h55);
        check("t2_ovf", overflow, 1);
        check("t2_level", level, 16);
        for (int i = 0; i < 16; i++) begin
            check("t2_drain", bus.out_data, 32'(i));
            pop_one();
        end
        check("t2_empty", empty, 1);
        check("t2_ovf_sticky", overflow, 1);
        clear();
        check("t2_ovf_clr", overflow, 0);
        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
        bus.in_data = 8'h77;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("t3_level", level, 16);
        check("t3_ovf", overflow, 0);
        for (int i = 0; i < 15; i++) begin
            check("t3_drain", bus.out_data, 32'(8'h21 + i));
            pop_one();
        end
        check("t3_last", bus.out_data, 8'h77);
        pop_one();
        check("t3_empty", empty, 1);
        // byte and error in one cycle
        bus.in_data = 8'h12;
        bus.in_valid = 1'b1;
        bus.in_error = ERR_STOP;
        bus.in_error_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        bus.in_error_valid = 1'b0;
        check("t4_level", level, 1);
        check("t4_err", bus.out_err, 2);
        check("t4_data", bus.out_data, 0);
        check("t4_errcnt", err_count, 1);
        pop_one();
        bus.in_error = ERR_NONE;
        bus.in_error_valid = 1'b1;
        cyc();
        bus.in_error_valid = 1'b0;
        check("t4_zero_level", level, 1);
        check("t4_zero_err", bus.out_err, 0);
        check("t4_zero_data", bus.out_data, 0);
        check("t4_zero_cnt", err_count, 1);
        pop_one();
        // saturation and clear
        clear();
        check("t5_clr0", err_count, 0);
        bus.in_error = ERR_PARITY;
        bus.in_error_valid = 1'b1;
        bus.out_ready = 1'b1;
        repeat (300) cyc();
        bus.in_error_valid = 1'b0;
        check("t5_sat", err_count, 255);
        check("t5_level", level, 1);
        cyc();
        bus.out_ready = 1'b0;
        check("t5_empty", empty, 1);
        clear();
        check("t5_clr", err_count, 0);
        clear_status = 1'b1;
        bus.in_error = ERR_FRAME;
        bus.in_error_valid = 1'b1;
        cyc();
        clear_status = 1'b0;
        bus.in_error_valid = 1'b0;
        check("t5_clr_evt", err_count, 1);
        check("t5_clr_tag", bus.out_err, 3);
        pop_one();
        // async reset while full and overflowed
        for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i));
        push_byte(8'hEE);
        check("t6_ovf_pre", overflow, 1);
        bus.in_data = 8'h50;
        bus.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("t6_level", level, 0);
        check("t6_valid", bus.out_valid, 0);
        check("t6_ovf", overflow, 0);
        check("t6_errcnt", err_count, 0);
        check("t6_data", bus.out_data, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        push_byte(8'h9E);
        check("t6_after_valid", bus.out_valid, 1);
        check("t6_after_data", bus.out_data, 8'h9E);
        check("t6_after_level", level, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
